fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 108 ++++++++++
 tb/tb_fifo_rd_stream.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO port and output stream bundle for fifo_rd_stream.
// master = the stream consumer block, slave = FIFO + downstream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              fifo_rden;
    logic [DATA_W-1:0] fifo_rddata;
    logic              fifo_rdempty;
    logic              fifo_rdfull;
    logic [ADDR_W-1:0] fifo_rdusedw;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        output fifo_rden, m_valid, m_data,
        input  fifo_rddata, fifo_rdempty, fifo_rdfull, fifo_rdusedw, m_ready
    );
    modport slave (
        input  fifo_rden, m_valid, m_data,
        output fifo_rddata, fifo_rdempty, fifo_rdfull, fifo_rdusedw, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Dual-clock FIFO read-side consumer: prefill, drain into a valid/ready stream
// through a 2-entry skid buffer, count underruns and re-prefill after one.
module fifo_rd_stream #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int START_LEVEL = 64
) (
    input  logic                 rdclk,
    input  logic                 rdrst,
    input  logic                 enable,
    fifo_rd_stream_if.master     bus,
    output logic                 underrun,
    output logic [15:0]          underrun_cnt,
    output logic [1:0]           state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;

    localparam logic [ADDR_W-1:0] START_LVL = ADDR_W'(START_LEVEL);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_underrun;
    logic [15:0]       r_underrun_cnt;

    logic              w_pop;
    logic              w_level_ok;
    logic              w_room;
    logic              w_rden;
    logic              w_underrun;
    logic              w_drained;

    assign w_pop      = (r_occ != 2'd0) & bus.m_ready;
    // usedw wraps to 0 at full, so full counts as "level reached"
    assign w_level_ok = (bus.fifo_rdusedw >= START_LVL) | bus.fifo_rdfull;
    assign w_room     = (({1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
    assign w_rden     = (r_state == STREAM) & ~bus.fifo_rdempty & w_room;
    assign w_underrun = (r_state == STREAM) & enable & bus.m_ready &
                        (r_occ == 2'd0) & ~r_inflight & bus.fifo_rdempty;
    assign w_drained  = (r_occ == 2'd0) & ~r_inflight;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = PREFILL;
            PREFILL: begin
                if (!enable)         w_state_nxt = IDLE;
                else if (w_level_ok) w_state_nxt = STREAM;
            end
            STREAM: begin
                if (!enable)         w_state_nxt = DRAIN;
                else if (w_underrun) w_state_nxt = PREFILL;
            end
            DRAIN:   if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Skid buffer: r_buf[0] is the head; the in-flight word lands at the tail
    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_inflight <= w_rden;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop && r_inflight) begin
                if (r_occ == 2'd2) begin
                    r_buf[0] <= r_buf[1];
                    r_buf[1] <= bus.fifo_rddata;
                end else begin
                    r_buf[0] <= bus.fifo_rddata;
                end
            end else if (w_pop) begin
                r_buf[0] <= r_buf[1];
            end else if (r_inflight) begin
                if (r_occ == 2'd0) r_buf[0] <= bus.fifo_rddata;
                else               r_buf[1] <= bus.fifo_rddata;
            end
        end
    end

    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else begin
            r_underrun <= w_underrun;
            if (w_underrun && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign bus.fifo_rden = w_rden;
    assign bus.m_valid   = (r_occ != 2'd0);
    assign bus.m_data    = r_buf[0];
    assign underrun      = r_underrun;
    assign underrun_cnt  = r_underrun_cnt;
    assign state         = r_state;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, scoreboard of words in
// write order, negedge monitor, directed phases plus a random backpressure phase.
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int DEPTH = 128;

    logic        rdclk = 1'b0;
    logic        rdrst = 1'b1;
    logic        enable = 1'b0;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [1:0]  state;
    logic        ovr_full = 1'b0;

    fifo_rd_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fifo_rd_stream #(.DATA_W(DW), .ADDR_W(AW), .START_LEVEL(64)) dut (
        .rdclk(rdclk), .rdrst(rdrst), .enable(enable), .bus(bus),
        .underrun(underrun), .underrun_cnt(underrun_cnt), .state(state)
    );

    always #5 rdclk = ~rdclk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb[$];
    int n_chk = 0, n_pass = 0;
    int n_rden = 0, n_und = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge rdclk);
        #1;
    endtask

    task automatic push_word(output logic [DW-1:0] w);
        w = DW'($urandom_range(0, 255));
        fifo_q.push_back(w);
        sb.push_back(w);
    endtask

    task automatic push_n(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) push_word(w);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int k = 0;
        while (state !== s && k < budget) begin tick(); k++; end
        check(nm, 32'(state), 32'(s));
    endtask

    task automatic wait_und(input int budget, input string nm);
        int k = 0;
        while (underrun !== 1'b1 && k < budget) begin tick(); k++; end
        check(nm, 32'(underrun), 32'd1);
    endtask

    // Registered-read FIFO model; flags settle 2 time units after each edge
    always begin
        int sz;
        sz = fifo_q.size();
        bus.fifo_rdempty = (sz == 0);
        bus.fifo_rdfull  = (sz >= DEPTH) || ovr_full;
        bus.fifo_rdusedw = AW'(sz);
        @(posedge rdclk);
        if (!rdrst && bus.fifo_rden === 1'b1) begin
            check("rden_not_empty", 32'(fifo_q.size() > 0), 32'd1);
            if (fifo_q.size() > 0) bus.fifo_rddata <= fifo_q.pop_front();
        end
        #2;
    end

    // Output monitor: ordering, hold-while-stalled, read only in STREAM
    logic          hold_chk = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge rdclk) begin
        if (rdrst) begin
            hold_chk = 1'b0;
        end else begin
            if (bus.fifo_rden === 1'b1) begin
                n_rden++;
                check("rden_in_stream", 32'(state), 32'd2);
            end
            if (underrun === 1'b1) n_und++;
            if (hold_chk) begin
                check("hold_valid", 32'(bus.m_valid), 32'd1);
                check("hold_data", 32'(bus.m_data), 32'(hold_data));
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (sb.size() == 0) check("sb_nonempty", 32'd0, 32'd1);
                else                check("stream_data", 32'(bus.m_data), 32'(sb.pop_front()));
            end
            hold_chk  = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
            hold_data = bus.m_data;
        end
    end

    initial begin
        logic [DW-1:0] w0, bp0, w;
        int bad, v, d, k, base;
        bus.m_ready = 1'b0;
        repeat (2) tick();
        check("rst_rden", 32'(bus.fifo_rden), 32'd0);
        check("rst_valid", 32'(bus.m_valid), 32'd0);
        check("rst_data", 32'(bus.m_data), 32'd0);
        check("rst_und", 32'(underrun), 32'd0);
        check("rst_cnt", 32'(underrun_cnt), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rdrst = 1'b0;

        // Prefill ramp, first-read latency, 64 back-to-back, underrun
        enable = 1'b1;
        bus.m_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (bus.fifo_rden !== 1'b0) bad++;
            push_word(w);
            if (i == 0) w0 = w;
        end
        check("no_rden_below_lvl", 32'(bad), 32'd0);
        tick();
        check("stream_at_lvl", 32'(state), 32'd2);
        check("first_rden", 32'(bus.fifo_rden), 32'd1);
        tick();
        check("lat_t1_novalid", 32'(bus.m_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(bus.m_valid), 32'd1);
        check("word0", 32'(bus.m_data), 32'(w0));
        v = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) v++;
            tick();
        end
        check("b2b_64", 32'(v), 32'd64);
        wait_und(10, "und1_pulse");
        check("und1_cnt", 32'(underrun_cnt), 32'd1);
        check("und1_state", 32'(state), 32'd1);
        tick();
        check("und1_one_cycle", 32'(underrun), 32'd0);

        // Below level after underrun: no reads
        base = n_rden;
        push_word(bp0);
        push_n(9);
        repeat (20) tick();
        check("no_rden_reprefill", 32'(n_rden - base), 32'd0);
        check("reprefill_state", 32'(state), 32'd1);

        // Backpressure: two reads fill the skid, head held, then full drain
        bus.m_ready = 1'b0;
        push_n(54);
        wait_state(2'd2, 10, "bp_stream");
        repeat (20) tick();
        check("bp_two_reads", 32'(n_rden - base), 32'd2);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_head", 32'(bus.m_data), 32'(bp0));
        bus.m_ready = 1'b1;
        v = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.m_valid === 1'b1) v++;
            tick();
        end
        check("bp_continuous", 32'(v), 32'd64);
        wait_und(10, "und2_pulse");
        check("und2_cnt", 32'(underrun_cnt), 32'd2);

        // Enable drop in steady flow: buffered + in-flight words still delivered
        push_n(80);
        wait_state(2'd2, 10, "drop_stream");
        repeat (10) tick();
        enable = 1'b0;
        d = 0;
        k = 0;
        while (state !== 2'd0 && k < 20) begin
            if (state === 2'd3 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) d++;
            tick();
            k++;
        end
        check("drain_to_idle", 32'(state), 32'd0);
        check("drain_words", 32'(d), 32'd2);
        check("drop_accounting", 32'(sb.size()), 32'(fifo_q.size()));

        // Asynchronous reset mid-STREAM with the skid buffer full
        push_n(40);
        enable = 1'b1;
        bus.m_ready = 1'b0;
        wait_state(2'd2, 10, "rst_stream");
        repeat (5) tick();
        #2 rdrst = 1'b1;
        #1;
        check("arst_rden", 32'(bus.fifo_rden), 32'd0);
        check("arst_valid", 32'(bus.m_valid), 32'd0);
        check("arst_data", 32'(bus.m_data), 32'd0);
        check("arst_cnt", 32'(underrun_cnt), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        fifo_q.delete();
        sb.delete();
        n_und = 0;
        tick();
        rdrst = 1'b0;
        enable = 1'b0;
        base = n_rden;
        push_n(70);
        repeat (10) tick();
        check("idle_no_rden", 32'(n_rden - base), 32'd0);
        check("idle_state", 32'(state), 32'd0);

        // Full FIFO (usedw wrapped to 0) must still start streaming
        push_n(58);
        tick();
        enable = 1'b1;
        wait_state(2'd2, 10, "full_to_stream");

        // Random backpressure and write pacing
        for (int i = 0; i < 400; i++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && fifo_q.size() < DEPTH) push_n(1);
            tick();
        end
        bus.m_ready = 1'b1;
        enable = 1'b0;
        wait_state(2'd0, 300, "rand_idle");
        check("rand_accounting", 32'(sb.size()), 32'(fifo_q.size()));
        check("rand_und_cnt", 32'(underrun_cnt), 32'(n_und));

        // Counter saturation: preload near the top, then force repeated underruns
        fifo_q.delete();
        sb.delete();
        tick();
        force dut.r_underrun_cnt = 16'hFFFD;
        #1 release dut.r_underrun_cnt;
        ovr_full = 1'b1;
        enable = 1'b1;
        base = n_und;
        k = 0;
        while (n_und < base + 5 && k < 60) begin tick(); k++; end
        check("sat_pulses", 32'(n_und - base), 32'd5);
        check("sat_cnt", 32'(underrun_cnt), 32'hFFFF);
        enable = 1'b0;
        ovr_full = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
